multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle RV32I core: sequences shared ALU, PC, IR and memory port.
//  Per instruction: fetch, decode, then execute/memory/writeback steps.
//  Drives alu_op to the ALU decoder; the decoder resolves funct3/funct7 into the ALU control code.
//  Handshakes with the single unified memory port; counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clk            in   1      core clock, all state on rising edge
//  resetn         in   1      asynchronous, active-low reset
//  op             in   7      opcode field from instruction register
//  mem_ready      in   1      memory completes current access this cycle
//  mem_read       out  1      memory read request (fetch or load)
//  mem_write      out  1      memory write request (store)
//  adr_src        out  1      0=PC, 1=ALU result register as memory address
//  ir_write       out  1      latch fetched word into IR / old PC
//  pc_update      out  1      unconditional PC write
//  branch         out  1      PC write if ALU zero flag set
//  reg_write      out  1      register file write enable
//  alu_src_a      out  2      00=PC, 01=oldPC, 10=rs1 data, 11=constant zero
//  alu_src_b      out  2      00=rs2 data, 01=immediate, 10=constant 4
//  result_src     out  2      00=ALU out reg, 01=memory data reg, 10=ALU result direct
//  alu_op         out  2      00=add, 01=sub (beq), 10=funct-decoded
//  illegal_instr  out  1      one-cycle pulse on unsupported opcode
//  retired        out  CNT_W  count of completed instructions
//  state_o        out  4      current state encoding, for debug
// BEHAVIOUR
//  States, encodings: S_RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5,
//   MEMWRITE=6, EXECR=7, EXECI=8, ALUWB=9, BEQ=10, JAL=11, LUI=12. Other codes -> FETCH.
//  Reset (resetn=0): state=S_RST; retired=0; every output 0. One cycle after release S_RST->FETCH.
//  All outputs are decoded from state, except ir_write/pc_update in FETCH (gated by mem_ready).
//  Unlisted outputs are 0 in each state.
//  FETCH: mem_read=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
//   Waits while mem_ready=0. When mem_ready=1: ir_write=1, pc_update=1, go to DECODE.
//  DECODE: a=01, b=01, alu_op=00 (branch/jump target precompute). Next state by op:
//   0000011,0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BEQ;
//   1101111->JAL; 0110111->LUI.
//   Any other op: illegal_instr=1 for this cycle, next FETCH, retired unchanged.
//  MEMADR: a=10, b=01, alu_op=00. Next MEMREAD if op=0000011, else MEMWRITE.
//  MEMREAD: mem_read=1, adr_src=1. Holds until mem_ready=1, then MEMWB.
//  MEMWB: result_src=01, reg_write=1 -> FETCH.
//  MEMWRITE: mem_write=1, adr_src=1. Holds until mem_ready=1, then FETCH.
//  EXECR: a=10, b=00, alu_op=10 -> ALUWB.
//  EXECI: a=10, b=01, alu_op=10 -> ALUWB.
//  LUI: a=11, b=01, alu_op=00 -> ALUWB.
//  ALUWB: result_src=00, reg_write=1 -> FETCH.
//  BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1 -> FETCH.
//  JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB (writes PC+4 to rd).
//  retired increments by 1 on the clock edge leaving MEMWB, MEMWRITE (with mem_ready=1),
//   ALUWB or BEQ. Wraps to 0 after all-ones. Never increments on the illegal path.
//  Latency, cycles from first FETCH cycle at zero wait states:
//   lw=5, sw=4, R/I-type=4, lui=4, beq=3, jal=4. Each wait cycle adds 1.
//  op is sampled only in DECODE and MEMADR. Changes in other states are ignored.
//  resetn asserted in any state (including mid memory wait): immediately S_RST, outputs 0.
//   Requests are dropped without waiting for mem_ready.
//  mem_read and mem_write are never 1 in the same cycle.
// TESTING
//  1 Reset released, mem_ready=1, op=0110011: states 0,1,2,7,9,1; reg_write only in ALUWB; retired=1.
//  2 lw, mem_ready low 3 cycles in MEMREAD: MEMREAD held 4 cycles with mem_read=1, adr_src=1;
//    then MEMWB with result_src=01; retired=1.
//  3 beq: BEQ cycle has alu_op=01, branch=1, pc_update=0; next FETCH; retired increments.
//  4 op=1110011 in DECODE: illegal_instr=1 for exactly 1 cycle; next FETCH; retired unchanged.
//  5 jal then lui back-to-back: JAL has pc_update=1 with a=01, b=10. LUI has a=11, b=01.
//    Both pass through ALUWB; retired=2.
//  6 resetn pulsed low in MEMWRITE while waiting: outputs 0 asynchronously, state_o=0, retired=0;
//    FETCH one cycle after release. CNT_W=4 run of 16 ALU instrs: retired wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Sequences the shared ALU, PC, IR and unified memory port through
// fetch / decode / execute / memory / writeback steps and counts retired
// instructions.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_update,
    output logic             branch,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_op,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_o
);

    // Opcodes recognised by the decoder
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpLui   = 7'b0110111;

    // ALU operand / result selector codes
    localparam logic [1:0] SrcAPc     = 2'b00;
    localparam logic [1:0] SrcAOldPc  = 2'b01;
    localparam logic [1:0] SrcARs1    = 2'b10;
    localparam logic [1:0] SrcAZero   = 2'b11;
    localparam logic [1:0] SrcBRs2    = 2'b00;
    localparam logic [1:0] SrcBImm    = 2'b01;
    localparam logic [1:0] SrcBFour   = 2'b10;
    localparam logic [1:0] ResAluOut  = 2'b00;
    localparam logic [1:0] ResMemData = 2'b01;
    localparam logic [1:0] ResAluDir  = 2'b10;
    localparam logic [1:0] AluAdd     = 2'b00;
    localparam logic [1:0] AluSub     = 2'b01;
    localparam logic [1:0] AluFunct   = 2'b10;

    typedef enum logic [3:0] {
        StRst      = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAdr   = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecR    = 4'd7,
        StExecI    = 4'd8,
        StAluWb    = 4'd9,
        StBeq      = 4'd10,
        StJal      = 4'd11,
        StLui      = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             op_legal;

    // Opcode legality, only meaningful while in DECODE
    always_comb begin
        op_legal = 1'b0;
        case (op)
            OpLoad, OpStore, OpRType, OpIType, OpBeq, OpJal, OpLui: op_legal = 1'b1;
            default:                                                op_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StRst;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRst:   state_d = StFetch;
            StFetch: state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBeq:           state_d = StBeq;
                    OpJal:           state_d = StJal;
                    OpLui:           state_d = StLui;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StLui:      state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StJal:      state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Output decode; only FETCH looks at mem_ready and only DECODE looks at op
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SrcAPc;
        alu_src_b     = SrcBRs2;
        result_src    = ResAluOut;
        alu_op        = AluAdd;
        illegal_instr = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read   = 1'b1;
                alu_src_a  = SrcAPc;
                alu_src_b  = SrcBFour;
                result_src = ResAluDir;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            StDecode: begin
                // Precompute branch / jump target from old PC + immediate
                alu_src_a     = SrcAOldPc;
                alu_src_b     = SrcBImm;
                illegal_instr = ~op_legal;
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
            end
            StMemRead: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
            end
            StMemWb: begin
                result_src = ResMemData;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluFunct;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluFunct;
            end
            StLui: begin
                alu_src_a = SrcAZero;
                alu_src_b = SrcBImm;
            end
            StAluWb: begin
                result_src = ResAluOut;
                reg_write  = 1'b1;
            end
            StBeq: begin
                alu_src_a  = SrcARs1;
                alu_src_b  = SrcBRs2;
                alu_op     = AluSub;
                result_src = ResAluOut;
                branch     = 1'b1;
            end
            StJal: begin
                // PC <= target held in ALU out; ALU forms old PC + 4 for rd
                alu_src_a  = SrcAOldPc;
                alu_src_b  = SrcBFour;
                result_src = ResAluOut;
                pc_update  = 1'b1;
            end
            default: ;
        endcase
    end

    // An instruction retires on the edge leaving its final state
    always_comb begin
        retire = 1'b0;
        case (state_q)
            StMemWb, StAluWb, StBeq: retire = 1'b1;
            StMemWrite:              retire = mem_ready;
            default:                 retire = 1'b0;
        endcase
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// A second instance with a 4-bit counter shares the stimulus to show wrap.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    // Control word: {mem_read, mem_write, adr_src, ir_write, pc_update, branch,
    //                reg_write, alu_src_a, alu_src_b, result_src, alu_op, illegal_instr}
    localparam logic [15:0] CW_ZERO  = 16'h0000;
    localparam logic [15:0] CW_FRDY  = {7'b1001100, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
    localparam logic [15:0] CW_FWAIT = {7'b1000000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
    localparam logic [15:0] CW_DEC   = {7'b0000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] CW_ILL   = {7'b0000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1};
    localparam logic [15:0] CW_MADR  = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] CW_MRD   = {7'b1010000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] CW_MWB   = {7'b0000001, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [15:0] CW_MWR   = {7'b0110000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] CW_EXR   = {7'b0000000, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [15:0] CW_EXI   = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0};
    localparam logic [15:0] CW_LUI   = {7'b0000000, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] CW_AWB   = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] CW_BEQ   = {7'b0000010, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0};
    localparam logic [15:0] CW_JAL   = {7'b0000100, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};

    logic        clk;
    logic        resetn;
    logic [6:0]  op;
    logic        mem_ready;

    logic        mem_read, mem_write, adr_src, ir_write, pc_update, branch, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src, alu_op;
    logic        illegal_instr;
    logic [31:0] retired;
    logic [3:0]  state_o;

    logic        mem_read4, mem_write4, adr_src4, ir_write4, pc_update4, branch4, reg_write4;
    logic [1:0]  alu_src_a4, alu_src_b4, result_src4, alu_op4;
    logic        illegal_instr4;
    logic [3:0]  retired4;
    logic [3:0]  state_o4;

    logic [15:0] ctl;

    int checks = 0;
    int fails  = 0;

    assign ctl = {mem_read, mem_write, adr_src, ir_write, pc_update, branch, reg_write,
                  alu_src_a, alu_src_b, result_src, alu_op, illegal_instr};

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .op(op), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_update(pc_update), .branch(branch),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_op(alu_op), .illegal_instr(illegal_instr),
        .retired(retired), .state_o(state_o)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .op(op), .mem_ready(mem_ready),
        .mem_read(mem_read4), .mem_write(mem_write4), .adr_src(adr_src4),
        .ir_write(ir_write4), .pc_update(pc_update4), .branch(branch4),
        .reg_write(reg_write4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
        .result_src(result_src4), .alu_op(alu_op4), .illegal_instr(illegal_instr4),
        .retired(retired4), .state_o(state_o4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in S_RST just after release, at a falling edge
    task automatic do_reset;
        resetn    = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        resetn    = 1'b0;
        op        = OP_R;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d expected 0", state_o);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ctl !== CW_ZERO) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected %h", ctl, CW_ZERO);
        end
        checks++;
        if (retired !== 32'd0 || retired4 !== 4'd0) begin
            fails++;
            $display("FAIL reset_retired: got %0d/%0d expected 0/0", retired, retired4);
        end
    endtask

    task automatic test_rtype;
        logic [3:0]  st  [6] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd9, 4'd1};
        logic [15:0] cwv [6] = '{CW_ZERO, CW_FRDY, CW_DEC, CW_EXR, CW_AWB, CW_FRDY};
        int          ret [6] = '{0, 0, 0, 0, 0, 1};
        do_reset();
        op = OP_R;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (state_o !== st[i]) begin
                fails++;
                $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state_o, st[i]);
            end
            checks++;
            if (ctl !== cwv[i]) begin
                fails++;
                $display("FAIL rtype_ctl[%0d]: got %h expected %h", i, ctl, cwv[i]);
            end
            checks++;
            if (retired !== 32'(ret[i])) begin
                fails++;
                $display("FAIL rtype_retired[%0d]: got %0d expected %0d", i, retired, ret[i]);
            end
            tick();
        end
    endtask

    task automatic test_load_wait;
        logic [3:0]  st  [11] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4,
                                  4'd5, 4'd1};
        logic [15:0] cwv [11] = '{CW_ZERO, CW_FWAIT, CW_FRDY, CW_DEC, CW_MADR, CW_MRD,
                                  CW_MRD, CW_MRD, CW_MRD, CW_MWB, CW_FRDY};
        logic        rdy [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                  1'b1, 1'b1};
        int          ret [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            // op changes after MEMADR must not affect the load path
            op        = (i <= 4) ? OP_LW : OP_SW;
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state_o !== st[i]) begin
                fails++;
                $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state_o, st[i]);
            end
            checks++;
            if (ctl !== cwv[i]) begin
                fails++;
                $display("FAIL lw_ctl[%0d]: got %h expected %h", i, ctl, cwv[i]);
            end
            checks++;
            if (retired !== 32'(ret[i])) begin
                fails++;
                $display("FAIL lw_retired[%0d]: got %0d expected %0d", i, retired, ret[i]);
            end
            tick();
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_beq;
        logic [3:0]  st  [5] = '{4'd0, 4'd1, 4'd2, 4'd10, 4'd1};
        logic [15:0] cwv [5] = '{CW_ZERO, CW_FRDY, CW_DEC, CW_BEQ, CW_FRDY};
        int          ret [5] = '{0, 0, 0, 0, 1};
        do_reset();
        op = OP_BEQ;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state_o !== st[i]) begin
                fails++;
                $display("FAIL beq_state[%0d]: got %0d expected %0d", i, state_o, st[i]);
            end
            checks++;
            if (ctl !== cwv[i]) begin
                fails++;
                $display("FAIL beq_ctl[%0d]: got %h expected %h", i, ctl, cwv[i]);
            end
            checks++;
            if (retired !== 32'(ret[i])) begin
                fails++;
                $display("FAIL beq_retired[%0d]: got %0d expected %0d", i, retired, ret[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal;
        logic [3:0]  st  [6] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
        logic [15:0] cwv [6] = '{CW_ZERO, CW_FRDY, CW_ILL, CW_FRDY, CW_ILL, CW_FRDY};
        do_reset();
        op = OP_SYS;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (state_o !== st[i]) begin
                fails++;
                $display("FAIL ill_state[%0d]: got %0d expected %0d", i, state_o, st[i]);
            end
            checks++;
            if (ctl !== cwv[i]) begin
                fails++;
                $display("FAIL ill_ctl[%0d]: got %h expected %h", i, ctl, cwv[i]);
            end
            checks++;
            if (retired !== 32'd0) begin
                fails++;
                $display("FAIL ill_retired[%0d]: got %0d expected 0", i, retired);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  st  [15] = '{4'd0, 4'd1, 4'd2, 4'd11, 4'd9, 4'd1, 4'd2, 4'd12, 4'd9,
                                  4'd1, 4'd2, 4'd8, 4'd9, 4'd1, 4'd2};
        logic [15:0] cwv [15] = '{CW_ZERO, CW_FRDY, CW_DEC, CW_JAL, CW_AWB, CW_FRDY,
                                  CW_DEC, CW_LUI, CW_AWB, CW_FRDY, CW_DEC, CW_EXI,
                                  CW_AWB, CW_FRDY, CW_DEC};
        logic [6:0]  ops [15] = '{OP_JAL, OP_JAL, OP_JAL, OP_JAL, OP_LUI, OP_LUI, OP_LUI,
                                  OP_LUI, OP_I, OP_I, OP_I, OP_I, OP_I, OP_SW, OP_SW};
        int          ret [15] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            op = ops[i];
            #1;
            checks++;
            if (state_o !== st[i]) begin
                fails++;
                $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, state_o, st[i]);
            end
            checks++;
            if (ctl !== cwv[i]) begin
                fails++;
                $display("FAIL b2b_ctl[%0d]: got %h expected %h", i, ctl, cwv[i]);
            end
            checks++;
            if (retired !== 32'(ret[i])) begin
                fails++;
                $display("FAIL b2b_retired[%0d]: got %0d expected %0d", i, retired, ret[i]);
            end
            tick();
        end
        // Zero-wait store: MEMADR, MEMWRITE, then back to FETCH
        checks++;
        if (state_o !== 4'd3 || ctl !== CW_MADR) begin
            fails++;
            $display("FAIL sw_madr: got %0d/%h expected 3/%h", state_o, ctl, CW_MADR);
        end
        tick();
        checks++;
        if (state_o !== 4'd6 || ctl !== CW_MWR) begin
            fails++;
            $display("FAIL sw_mwrite: got %0d/%h expected 6/%h", state_o, ctl, CW_MWR);
        end
        tick();
        checks++;
        if (state_o !== 4'd1 || retired !== 32'd4) begin
            fails++;
            $display("FAIL sw_done: got %0d/%0d expected 1/4", state_o, retired);
        end
    endtask

    task automatic test_reset_in_store;
        do_reset();
        op = OP_R;
        // S_RST, FETCH, DECODE, EXECR, ALUWB -> FETCH with one retired
        repeat (5) tick();
        op = OP_SW;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (state_o !== 4'd6 || ctl !== CW_MWR || retired !== 32'd1) begin
            fails++;
            $display("FAIL swwait_pre: got %0d/%h/%0d expected 6/%h/1",
                     state_o, ctl, retired, CW_MWR);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || ctl !== CW_ZERO || retired !== 32'd0) begin
            fails++;
            $display("FAIL swwait_async_rst: got %0d/%h/%0d expected 0/%h/0",
                     state_o, ctl, retired, CW_ZERO);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            fails++;
            $display("FAIL swwait_release: got %0d expected 0", state_o);
        end
        tick();
        checks++;
        if (state_o !== 4'd1 || ctl !== CW_FRDY) begin
            fails++;
            $display("FAIL swwait_fetch: got %0d/%h expected 1/%h", state_o, ctl, CW_FRDY);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        op = OP_R;
        tick();
        repeat (15 * 4) tick();
        checks++;
        if (state_o4 !== 4'd1 || retired4 !== 4'hf || retired !== 32'd15) begin
            fails++;
            $display("FAIL wrap_15: got %0d/%0d/%0d expected 1/15/15",
                     state_o4, retired4, retired);
        end
        repeat (4) tick();
        checks++;
        if (retired4 !== 4'h0) begin
            fails++;
            $display("FAIL wrap_16_cnt4: got %0d expected 0", retired4);
        end
        checks++;
        if (retired !== 32'd16) begin
            fails++;
            $display("FAIL wrap_16_cnt32: got %0d expected 16", retired);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_beq();
        test_illegal();
        test_back_to_back();
        test_reset_in_store();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
